// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, fetch FSM encoding and PC helper
package inst_fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - DEPTH-entry FIFO of {pc, inst}; flush has priority over push/pop
module fetch_buffer
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [XLEN-1:0]   push_pc,
  input  logic [INST_W-1:0] push_inst,
  output logic [XLEN-1:0]   head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CNT_W-1){1'b0}}, do_push} - {{(CNT_W-1){1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch PC, one-outstanding imem req/ack, redirect/drop/halt control
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemRdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPC,
  output logic        o_instValid,
  input  logic        i_instReady,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4,
  output logic        o_misaligned
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state, state_nxt;
  logic [XLEN-1:0]   fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0]   req_addr;
  logic              misaligned;
  logic              redirect_act, mis_redirect;
  logic              push, pop, space_after_push, load_addr;
  logic [XLEN-1:0]   head_pc;
  logic [INST_W-1:0] head_inst;
  logic              full, empty;
  logic [CNT_W-1:0]  count;

  // HALT ignores redirects entirely; only reset leaves it.
  assign redirect_act = i_redirect && (state != ST_HALT);
  assign mis_redirect = redirect_act && (i_redirectPC[1:0] != 2'b00);
  assign push         = (state == ST_REQ) && i_imemAck && !redirect_act;
  assign pop          = !empty && i_instReady && !redirect_act;
  assign space_after_push = pop ? !full : (count < CNT_W'(DEPTH - 1));

  fetch_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_buf (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_act),
    .push_pc   (fetch_pc),
    .push_inst (i_imemRdata),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (redirect_act)  fetch_pc_nxt = i_redirectPC;
    else if (push)     fetch_pc_nxt = pc_next(fetch_pc);

    case (state)
      ST_IDLE: begin
        if (mis_redirect)                 state_nxt = ST_HALT;
        else if (redirect_act)            state_nxt = ST_REQ;
        else if (!full || pop)            state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (mis_redirect)                 state_nxt = i_imemAck ? ST_HALT : ST_DROP;
        else if (redirect_act)            state_nxt = i_imemAck ? ST_REQ : ST_DROP;
        else if (i_imemAck)               state_nxt = space_after_push ? ST_REQ : ST_IDLE;
      end
      ST_DROP: begin
        if (i_imemAck)                    state_nxt = (misaligned || mis_redirect) ? ST_HALT : ST_REQ;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase

    // The request address only moves when a fresh request starts.
    load_addr = (state_nxt == ST_REQ) && !((state == ST_REQ) && !i_imemAck);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      fetch_pc   <= RESET_PC;
      req_addr   <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (load_addr)    req_addr   <= fetch_pc_nxt;
      if (mis_redirect) misaligned <= 1'b1;
    end
  end

  assign o_imemReq    = (state == ST_REQ) || (state == ST_DROP);
  assign o_imemAddr   = req_addr;
  assign o_instValid  = !empty;
  assign o_inst       = empty ? '0 : head_inst;
  assign o_pc         = empty ? '0 : head_pc;
  assign o_pcPlus4    = empty ? '0 : pc_next(head_pc);
  assign o_misaligned = misaligned;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized self-checking bench for inst_fetch with memory model and PC scoreboard
module tb_inst_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemAck = 1'b0;
  logic [31:0] i_imemRdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirectPC = '0;
  logic        o_instValid;
  logic        i_instReady = 1'b0;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_pcPlus4;
  logic        o_misaligned;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_imemReq    (o_imemReq),
    .o_imemAddr   (o_imemAddr),
    .i_imemAck    (i_imemAck),
    .i_imemRdata  (i_imemRdata),
    .i_redirect   (i_redirect),
    .i_redirectPC (i_redirectPC),
    .o_instValid  (o_instValid),
    .i_instReady  (i_instReady),
    .o_inst       (o_inst),
    .o_pc         (o_pc),
    .o_pcPlus4    (o_pcPlus4),
    .o_misaligned (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  logic [31:0] exp_pc = 32'h0;
  bit          halted = 1'b0;
  int          mem_cnt = 0;
  int          cur_lat = 1;
  int          mem_lat = 1;
  bit          mem_rand = 1'b0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  // One clock: memory model answers, scoreboard observes the handshake, then the edge.
  task automatic cycle();
    bit ack;
    bit req_seen;
    ack = 1'b0;
    req_seen = 1'b0;
    if (!i_rst && o_imemReq) begin
      req_seen = 1'b1;
      if (mem_cnt == 0) begin
        mem_addr = o_imemAddr;
        cur_lat  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      end else begin
        checks++;
        if (o_imemAddr !== mem_addr) begin
          errors++;
          $display("FAIL addr_stable: got %h expected %h", o_imemAddr, mem_addr);
        end
      end
      ack = (mem_cnt >= cur_lat);
    end
    i_imemAck   = ack;
    i_imemRdata = ack ? inst_of(mem_addr) : $urandom;

    if (i_rst) begin
      exp_pc = 32'h0;
      halted = 1'b0;
    end else if (i_redirect && !halted) begin
      exp_pc = i_redirectPC;
      if (i_redirectPC[1:0] != 2'b00) halted = 1'b1;
    end else if (o_instValid && i_instReady) begin
      checks++;
      if (o_pc !== exp_pc) begin
        errors++;
        $display("FAIL sb_pc: got %h expected %h", o_pc, exp_pc);
      end
      checks++;
      if (o_inst !== inst_of(exp_pc)) begin
        errors++;
        $display("FAIL sb_inst: got %h expected %h", o_inst, inst_of(exp_pc));
      end
      checks++;
      if (o_pcPlus4 !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL sb_pcplus4: got %h expected %h", o_pcPlus4, exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
      pops++;
    end

    @(posedge i_clk);
    #1;
    if (i_rst || ack) mem_cnt = 0;
    else if (req_seen) mem_cnt++;
    i_imemAck = 1'b0;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    i_redirect = 1'b0;
    cycle();
    cycle();
    i_rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if ({o_imemReq, o_instValid, o_misaligned} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {o_imemReq, o_instValid, o_misaligned});
    end
    checks++;
    if (o_imemAddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected %h", o_imemAddr, 32'h0);
    end
    checks++;
    if ({o_inst, o_pc, o_pcPlus4} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {o_inst, o_pc, o_pcPlus4});
    end
  endtask

  task automatic test_stream();
    int start;
    mem_rand = 1'b0;
    mem_lat = 1;
    i_instReady = 1'b1;
    apply_reset();
    checks++;
    if (!(o_imemReq === 1'b1 && o_imemAddr === 32'h0 && o_instValid === 1'b0)) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h valid=%b expected 1 0 0", o_imemReq, o_imemAddr, o_instValid);
    end
    cycle();
    checks++;
    if (o_instValid !== 1'b0) begin
      errors++;
      $display("FAIL ack_no_bypass: got %b expected 0", o_instValid);
    end
    cycle();
    checks++;
    if (!(o_instValid === 1'b1 && o_pc === 32'h0)) begin
      errors++;
      $display("FAIL first_valid: got valid=%b pc=%h expected 1 0", o_instValid, o_pc);
    end
    start = pops;
    for (int k = 0; k < 200 && (pops - start) < 12; k++) cycle();
    checks++;
    if (pops - start < 12) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 12", pops - start);
    end
  endtask

  task automatic test_backpressure();
    int start;
    mem_rand = 1'b0;
    mem_lat = 1;
    i_instReady = 1'b0;
    apply_reset();
    repeat (12) cycle();
    checks++;
    if (!(o_instValid === 1'b1 && o_pc === 32'h0 && o_imemReq === 1'b0)) begin
      errors++;
      $display("FAIL full_hold: got valid=%b pc=%h req=%b expected 1 0 0", o_instValid, o_pc, o_imemReq);
    end
    i_instReady = 1'b1;
    cycle();
    i_instReady = 1'b0;
    checks++;
    if (!(o_instValid === 1'b1 && o_pc === 32'h4)) begin
      errors++;
      $display("FAIL second_entry: got valid=%b pc=%h expected 1 4", o_instValid, o_pc);
    end
    repeat (10) cycle();
    checks++;
    if (!(o_pc === 32'h4 && o_imemReq === 1'b0)) begin
      errors++;
      $display("FAIL refill_hold: got pc=%h req=%b expected 4 0", o_pc, o_imemReq);
    end
    i_instReady = 1'b1;
    start = pops;
    for (int k = 0; k < 100 && (pops - start) < 6; k++) cycle();
    checks++;
    if (pops - start < 6) begin
      errors++;
      $display("FAIL drain_count: got %0d expected 6", pops - start);
    end
  endtask

  task automatic test_drop();
    bit reached;
    mem_rand = 1'b0;
    mem_lat = 1;
    i_instReady = 1'b0;
    apply_reset();
    repeat (10) cycle();
    mem_lat = 3;
    i_instReady = 1'b1;
    cycle();
    i_instReady = 1'b0;
    checks++;
    if (!(o_imemReq === 1'b1 && o_imemAddr === 32'h8)) begin
      errors++;
      $display("FAIL req8: got req=%b addr=%h expected 1 8", o_imemReq, o_imemAddr);
    end
    cycle();
    i_redirect = 1'b1;
    i_redirectPC = 32'h100;
    cycle();
    i_redirect = 1'b0;
    mem_lat = 1;
    checks++;
    if (!(o_imemReq === 1'b1 && o_imemAddr === 32'h8 && o_instValid === 1'b0)) begin
      errors++;
      $display("FAIL drop_hold: got req=%b addr=%h valid=%b expected 1 8 0", o_imemReq, o_imemAddr, o_instValid);
    end
    reached = 1'b0;
    for (int k = 0; k < 10 && !reached; k++) begin
      if (o_imemReq && o_imemAddr == 32'h100) reached = 1'b1;
      else cycle();
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL drop_refetch: got addr=%h expected %h", o_imemAddr, 32'h100);
    end
    i_instReady = 1'b1;
    for (int k = 0; k < 10 && !o_instValid; k++) cycle();
    checks++;
    if (!(o_instValid === 1'b1 && o_pc === 32'h100)) begin
      errors++;
      $display("FAIL drop_pc: got valid=%b pc=%h expected 1 100", o_instValid, o_pc);
    end
  endtask

  task automatic test_redirect_ack();
    mem_rand = 1'b0;
    mem_lat = 0;
    i_instReady = 1'b1;
    apply_reset();
    for (int k = 0; k < 10 && !(o_imemReq && o_instValid); k++) cycle();
    i_redirect = 1'b1;
    i_redirectPC = 32'h200;
    cycle();
    i_redirect = 1'b0;
    checks++;
    if (!(o_instValid === 1'b0 && o_imemReq === 1'b1 && o_imemAddr === 32'h200)) begin
      errors++;
      $display("FAIL redir_ack: got valid=%b req=%b addr=%h expected 0 1 200", o_instValid, o_imemReq, o_imemAddr);
    end
    cycle();
    checks++;
    if (!(o_instValid === 1'b1 && o_pc === 32'h200 && o_pcPlus4 === 32'h204)) begin
      errors++;
      $display("FAIL redir_pc: got valid=%b pc=%h p4=%h expected 1 200 204", o_instValid, o_pc, o_pcPlus4);
    end
  endtask

  task automatic test_misaligned();
    mem_rand = 1'b1;
    i_instReady = 1'b1;
    apply_reset();
    repeat (5) cycle();
    i_redirect = 1'b1;
    i_redirectPC = 32'h102;
    cycle();
    i_redirect = 1'b0;
    checks++;
    if (!(o_misaligned === 1'b1 && o_instValid === 1'b0)) begin
      errors++;
      $display("FAIL mis_set: got mis=%b valid=%b expected 1 0", o_misaligned, o_instValid);
    end
    repeat (8) cycle();
    checks++;
    if (!(o_imemReq === 1'b0 && o_instValid === 1'b0 && o_misaligned === 1'b1)) begin
      errors++;
      $display("FAIL halt_quiet: got req=%b valid=%b mis=%b expected 0 0 1", o_imemReq, o_instValid, o_misaligned);
    end
    i_redirect = 1'b1;
    i_redirectPC = 32'h40;
    cycle();
    i_redirect = 1'b0;
    repeat (3) cycle();
    checks++;
    if (!(o_imemReq === 1'b0 && o_instValid === 1'b0 && o_misaligned === 1'b1)) begin
      errors++;
      $display("FAIL halt_sticky: got req=%b valid=%b mis=%b expected 0 0 1", o_imemReq, o_instValid, o_misaligned);
    end
  endtask

  task automatic test_reset_wrap();
    int start;
    mem_rand = 1'b0;
    mem_lat = 3;
    i_instReady = 1'b1;
    i_rst = 1'b1;
    cycle();
    checks++;
    if (o_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL mis_clear: got %b expected 0", o_misaligned);
    end
    i_rst = 1'b0;
    cycle();
    cycle();
    i_rst = 1'b1;
    cycle();
    checks++;
    if ({o_imemReq, o_instValid, o_misaligned, o_imemAddr, o_inst, o_pc, o_pcPlus4} !== 131'h0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b valid=%b addr=%h pc=%h expected all 0", o_imemReq, o_instValid, o_imemAddr, o_pc);
    end
    i_rst = 1'b0;
    cycle();
    checks++;
    if (!(o_imemReq === 1'b1 && o_imemAddr === 32'h0)) begin
      errors++;
      $display("FAIL refetch: got req=%b addr=%h expected 1 0", o_imemReq, o_imemAddr);
    end
    mem_lat = 1;
    i_redirect = 1'b1;
    i_redirectPC = 32'hFFFF_FFFC;
    cycle();
    i_redirect = 1'b0;
    for (int k = 0; k < 20 && !o_instValid; k++) cycle();
    checks++;
    if (!(o_instValid === 1'b1 && o_pc === 32'hFFFF_FFFC && o_pcPlus4 === 32'h0)) begin
      errors++;
      $display("FAIL wrap_head: got valid=%b pc=%h p4=%h expected 1 fffffffc 0", o_instValid, o_pc, o_pcPlus4);
    end
    start = pops;
    for (int k = 0; k < 60 && (pops - start) < 4; k++) cycle();
    checks++;
    if (pops - start < 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected 4", pops - start);
    end
  endtask

  task automatic test_random();
    int start;
    mem_rand = 1'b1;
    apply_reset();
    start = pops;
    for (int k = 0; k < 600; k++) begin
      i_instReady = ($urandom_range(0, 3) != 0);
      i_redirect  = ($urandom_range(0, 30) == 0);
      i_redirectPC = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    i_redirect = 1'b0;
    checks++;
    if (pops - start < 50) begin
      errors++;
      $display("FAIL random_progress: got %0d expected at least 50", pops - start);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_redirect_ack();
    test_misaligned();
    test_reset_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
